// File: rtl/apb_reg_slave_if.sv
// apb_reg_slave_if -- APB3 bus bundle for one completer slot.
//   PSEL, PENABLE, PWRITE, PADDR[7:0], PWDATA[31:0] : requester -> completer
//   PRDATA[31:0], PREADY, PSLVERR                   : completer -> requester
interface apb_reg_slave_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_reg_slave.sv
// apb_reg_slave -- APB3 completer with 15 read-write registers (0x00..0x38)
// and a read-only completed-transfer counter at 0x3C.
//   HCLK  : clock, rising edge
//   HRST  : asynchronous active-low reset
//   apb   : apb_reg_slave_if.slave (PSEL/PENABLE/PWRITE/PADDR/PWDATA in,
//           PRDATA/PREADY/PSLVERR out)
// Parameters: WAIT_STATES (0..3) access-phase wait cycles, RESET_VAL for
// every read-write register.
module apb_reg_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic           HCLK,
  input  logic           HRST,
  apb_reg_slave_if.slave apb
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [1:0] WS_CNT  = 2'(WAIT_STATES);
  localparam logic [3:0] CNT_IDX = 4'hF;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  word_q, word_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] regs_q [15];
  logic [15:0] txn_q;

  logic        commit;
  logic        setup_err;
  logic        ready;
  logic [31:0] rd_mux;

  // Only the word index is kept; everything else about the address is
  // folded into the error flag at setup.
  assign setup_err = (apb.PADDR[1:0] != 2'b00) ||
                     (apb.PADDR[7:6] != 2'b00) ||
                     (apb.PWRITE && apb.PADDR[5:2] == CNT_IDX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    write_d = write_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (apb.PSEL) begin
          state_d = S_ACCESS;
          word_d  = apb.PADDR[5:2];
          write_d = apb.PWRITE;
          if (apb.PENABLE) begin
            // access phase without a setup: complete at once with an error
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            err_d = setup_err;
            cnt_d = WS_CNT;
          end
        end
      end
      S_ACCESS: begin
        if (!apb.PSEL) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRST) begin
    if (!HRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRST) begin
    if (!HRST) begin
      for (int unsigned i = 0; i < 15; i++) regs_q[i] <= RESET_VAL;
      txn_q <= '0;
    end else if (commit && !err_q) begin
      if (write_q && word_q != CNT_IDX) regs_q[word_q] <= apb.PWDATA;
      txn_q <= txn_q + 16'd1;
    end
  end

  // Outputs come only from registered state, never from the P* inputs.
  assign ready  = (state_q == S_ACCESS) && (cnt_q == '0);
  assign rd_mux = (word_q == CNT_IDX) ? {16'h0000, txn_q} : regs_q[word_q];

  assign apb.PREADY  = ready;
  assign apb.PSLVERR = ready && err_q;
  assign apb.PRDATA  = (ready && !write_q && !err_q) ? rd_mux : '0;

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave -- four completers with WAIT_STATES 0..3 on a shared
// clock/reset, each on its own bus; table vectors, directed corner cases
// and random traffic checked against a register-map model.
module tb_apb_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  psel_v;
  logic        penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata_v  [4];
  logic        pready_v  [4];
  logic        pslverr_v [4];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    apb_reg_slave_if bus ();
    assign bus.PSEL    = psel_v[k];
    assign bus.PENABLE = penable;
    assign bus.PWRITE  = pwrite;
    assign bus.PADDR   = paddr;
    assign bus.PWDATA  = pwdata;
    assign prdata_v[k]  = bus.PRDATA;
    assign pready_v[k]  = bus.PREADY;
    assign pslverr_v[k] = bus.PSLVERR;
    apb_reg_slave #(
      .WAIT_STATES(k),
      .RESET_VAL  ((k == 1) ? 32'h0000_0000 : (32'hC0DE_0000 | k))
    ) u_dut (
      .HCLK(clk),
      .HRST(rst_n),
      .apb (bus)
    );
  end

  // ---------------- reference model ----------------
  logic [31:0] m_regs [4][15];
  logic [15:0] m_cnt  [4];

  function automatic logic [31:0] rv(input int k);
    return (k == 1) ? 32'h0 : (32'hC0DE_0000 | 32'(k));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 15; i++) m_regs[k][i] = rv(k);
      m_cnt[k] = '0;
    end
  endtask

  task automatic model_xfer(input int k, input bit wr, input logic [7:0] a,
                            input logic [31:0] d, output logic e, output logic [31:0] r);
    e = (a % 4 != 0) || (a >= 8'h40) || (wr && a == 8'h3C);
    r = '0;
    if (!e) begin
      if (wr) m_regs[k][int'(a) / 4] = d;
      else if (a == 8'h3C) r = {16'h0, m_cnt[k]};
      else r = m_regs[k][int'(a) / 4];
      m_cnt[k] = m_cnt[k] + 16'd1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // ---------------- bus driver ----------------
  task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int ncyc,
                      output logic post_rdy);
    @(negedge clk);
    psel_v = '0; psel_v[k] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    ncyc = 1;
    while (pready_v[k] !== 1'b1 && ncyc < 12) begin
      @(negedge clk);
      ncyc++;
    end
    rd = prdata_v[k];
    er = pslverr_v[k];
    @(posedge clk);
    #1;
    post_rdy = pready_v[k];
    psel_v = '0; penable = 1'b0;
  endtask

  task automatic run(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er);
    int n;
    logic post, e_exp;
    logic [31:0] r_exp;
    xfer(k, wr, a, d, rd, er, n, post);
    model_xfer(k, wr, a, d, e_exp, r_exp);
    chk($sformatf("prdata k%0d a%h", k, a), rd, r_exp);
    chk($sformatf("pslverr k%0d a%h", k, a), 32'(er), 32'(e_exp));
    chk($sformatf("access_cycles k%0d", k), 32'(n), 32'(k + 1));
    chk($sformatf("pready_one_cycle k%0d", k), 32'(post), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tv [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;

    tv[0]  = '{1'b1, 8'h0C, 32'hAAAA_AAAA, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 8'h0C, 32'h0,         1'b0, 32'hAAAA_AAAA};
    tv[2]  = '{1'b0, 8'h3C, 32'h0,         1'b0, 32'h2};
    tv[3]  = '{1'b1, 8'h3C, 32'h55,        1'b1, 32'h0};
    tv[4]  = '{1'b1, 8'h40, 32'h55,        1'b1, 32'h0};
    tv[5]  = '{1'b1, 8'h0E, 32'h55,        1'b1, 32'h0};
    tv[6]  = '{1'b0, 8'h0C, 32'h0,         1'b0, 32'hAAAA_AAAA};
    tv[7]  = '{1'b0, 8'h3C, 32'h0,         1'b0, 32'h4};
    tv[8]  = '{1'b0, 8'h3D, 32'h0,         1'b1, 32'h0};
    tv[9]  = '{1'b0, 8'h44, 32'h0,         1'b1, 32'h0};
    tv[10] = '{1'b0, 8'h3C, 32'h0,         1'b0, 32'h5};

    psel_v = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset pready k%0d", k), 32'(pready_v[k]), 32'd0);
      chk($sformatf("reset pslverr k%0d", k), 32'(pslverr_v[k]), 32'd0);
      chk($sformatf("reset prdata k%0d", k), prdata_v[k], 32'd0);
    end
    rst_n = 1'b1;

    // first read after reset
    run(1, 1'b0, 8'h0C, 32'h0, rd, er);
    chk("reset_read_data", rd, 32'h0);
    chk("reset_read_err", 32'(er), 32'd0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      run(1, tv[i].wr, tv[i].addr, tv[i].data, rd, er);
      chk($sformatf("tv%0d rd", i), rd, tv[i].exp_rd);
      chk($sformatf("tv%0d err", i), 32'(er), 32'(tv[i].exp_err));
    end

    // zero and three wait states, back-to-back pairs
    for (int k = 0; k < 4; k += 3) begin
      run(k, 1'b1, 8'h00, 32'h1234_5678, rd, er);
      run(k, 1'b0, 8'h00, 32'h0, rd, er);
      chk($sformatf("ws%0d reg0", k), rd, 32'h1234_5678);
      run(k, 1'b1, 8'h38, 32'h9ABC_DEF0, rd, er);
      run(k, 1'b0, 8'h38, 32'h0, rd, er);
      chk($sformatf("ws%0d reg14", k), rd, 32'h9ABC_DEF0);
    end

    // abort in the first access cycle (WAIT_STATES=2)
    run(2, 1'b0, 8'h3C, 32'h0, rd, er);
    @(negedge clk);
    psel_v = 4'b0100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    psel_v = '0; penable = 1'b0;
    @(negedge clk);
    run(2, 1'b0, 8'h04, 32'h0, rd, er);
    chk("abort reg1", rd, 32'hC0DE_0002);
    run(2, 1'b0, 8'h3C, 32'h0, rd, er);

    // PSEL and PENABLE together from IDLE
    @(negedge clk);
    psel_v = 4'b0100; penable = 1'b1; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("proto pready", 32'(pready_v[2]), 32'd1);
    chk("proto pslverr", 32'(pslverr_v[2]), 32'd1);
    chk("proto prdata", prdata_v[2], 32'd0);
    @(posedge clk);
    #1;
    chk("proto pready_drop", 32'(pready_v[2]), 32'd0);
    psel_v = '0; penable = 1'b0;
    run(2, 1'b0, 8'h10, 32'h0, rd, er);
    run(2, 1'b0, 8'h3C, 32'h0, rd, er);

    // reset during the wait state of a write
    run(2, 1'b1, 8'h08, 32'h1111_2222, rd, er);
    @(negedge clk);
    psel_v = 4'b0100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h0BAD_F00D;
    @(negedge clk);
    penable = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset pready", 32'(pready_v[2]), 32'd0);
    chk("midreset pslverr", 32'(pslverr_v[2]), 32'd0);
    model_reset();
    psel_v = '0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(2, 1'b0, 8'h08, 32'h0, rd, er);
    chk("midreset reg2", rd, 32'hC0DE_0002);

    // random traffic on all four slots
    for (int i = 0; i < 400; i++) begin
      int          k;
      bit          wr;
      logic [7:0]  a;
      logic [31:0] d;
      k  = $urandom_range(0, 3);
      wr = 1'($urandom % 2);
      a  = 8'($urandom_range(0, 8'h47));
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      d  = $urandom;
      run(k, wr, a, d, rd, er);
      if ($urandom % 3 == 0) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
